// File: rtl/led_ctrl_multi.sv
// Multi-channel LED driver. Each channel runs OFF, ON, BLINK (programmable
// half-period) or PWM (programmable duty against a shared free-running
// counter). Channels are configured through a one-cycle write port and each
// has its own enable switch.
//
// Ports:
//   clk_in      system clock
//   rst         synchronous, active-high reset
//   switch_on   per-channel enable; low forces the channel output to 0
//   cfg_we      configuration write strobe (one cycle)
//   cfg_ch      target channel of the write
//   cfg_mode    0 OFF, 1 ON, 2 BLINK, 3 PWM
//   cfg_period  BLINK half-period in clk_in cycles (0 behaves as 1)
//   cfg_duty    PWM high count per 2^PWM_W window
//   cfg_err     one-cycle pulse after a write to a non-existent channel
//   led_on      registered LED outputs
module led_ctrl_multi #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned DIV_W    = 32,
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned DEF_HALF = 50000000,
  parameter int unsigned CH_W     = 2
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [N_CH-1:0]   switch_on,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [DIV_W-1:0]  cfg_period,
  input  logic [PWM_W-1:0]  cfg_duty,
  output logic              cfg_err,
  output logic [N_CH-1:0]   led_on
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  // Per-channel configuration and blink state
  mode_e            mode_q  [N_CH];
  mode_e            mode_d  [N_CH];
  logic [DIV_W-1:0] half_q  [N_CH];
  logic [DIV_W-1:0] half_d  [N_CH];
  logic [PWM_W-1:0] duty_q  [N_CH];
  logic [PWM_W-1:0] duty_d  [N_CH];
  logic [DIV_W-1:0] cnt_q   [N_CH];
  logic [DIV_W-1:0] cnt_d   [N_CH];
  logic [DIV_W-1:0] top_cnt [N_CH];
  logic [N_CH-1:0]  phase_q;
  logic [N_CH-1:0]  phase_d;

  // Shared PWM counter and registered outputs
  logic [PWM_W-1:0] pwm_q;
  logic [PWM_W-1:0] pwm_d;
  logic [N_CH-1:0]  led_d;
  logic             err_d;

  // Write address decode
  logic [31:0]      ch_idx;
  logic             ch_ok;

  assign ch_idx = 32'(cfg_ch);
  assign ch_ok  = (ch_idx < N_CH);

  // Last counter value of a blink half-period; a stored half of 0 acts as 1
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      top_cnt[i] = (half_q[i] == '0) ? '0 : (half_q[i] - DIV_W'(1));
    end
  end

  // Next-state and output logic
  always_comb begin
    pwm_d   = pwm_q + PWM_W'(1);
    err_d   = cfg_we && !ch_ok;
    phase_d = phase_q;
    led_d   = '0;
    for (int i = 0; i < N_CH; i++) begin
      mode_d[i] = mode_q[i];
      half_d[i] = half_q[i];
      duty_d[i] = duty_q[i];
      cnt_d[i]  = cnt_q[i];

      // Output follows the configuration held before this edge
      if (switch_on[i]) begin
        unique case (mode_q[i])
          MODE_OFF:   led_d[i] = 1'b0;
          MODE_ON:    led_d[i] = 1'b1;
          MODE_BLINK: led_d[i] = phase_q[i];
          MODE_PWM:   led_d[i] = (pwm_q < duty_q[i]);
          default:    led_d[i] = 1'b0;
        endcase
      end

      // Blink timing only advances while enabled in BLINK
      if (!switch_on[i] || (mode_q[i] != MODE_BLINK)) begin
        cnt_d[i]   = '0;
        phase_d[i] = 1'b0;
      end else if (cnt_q[i] >= top_cnt[i]) begin
        cnt_d[i]   = '0;
        phase_d[i] = ~phase_q[i];
      end else begin
        cnt_d[i]   = cnt_q[i] + DIV_W'(1);
      end

      // A write overrides a coincident toggle and restarts the blink
      if (cfg_we && ch_ok && (ch_idx == 32'(i))) begin
        mode_d[i]  = mode_e'(cfg_mode);
        half_d[i]  = cfg_period;
        duty_d[i]  = cfg_duty;
        cnt_d[i]   = '0;
        phase_d[i] = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i] <= MODE_BLINK;
        half_q[i] <= DIV_W'(DEF_HALF);
        duty_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      phase_q <= '0;
      pwm_q   <= '0;
      led_on  <= '0;
      cfg_err <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i] <= mode_d[i];
        half_q[i] <= half_d[i];
        duty_q[i] <= duty_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      phase_q <= phase_d;
      pwm_q   <= pwm_d;
      led_on  <= led_d;
      cfg_err <= err_d;
    end
  end

endmodule
